// File: rtl/data_memory_pkg.sv
// Default geometry for the datapath data memory.
package data_memory_pkg;
    localparam int DM_DATA_WIDTH = 8;
    localparam int DM_ADDR_WIDTH = 8;
    localparam int DM_DEPTH      = 256;
endpackage

// File: rtl/data_memory.sv
// Byte-addressable data memory for the MEM stage.
// Synchronous write and clear; combinational read gated by memRead.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DEPTH      = DM_DEPTH
) (
    input  logic                  clk,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    input  logic                  rst
);
    // Only the low bits needed to cover DEPTH index the array, so a
    // shallower memory wraps instead of reading past its end.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]      idx;

    assign idx = address[IDX_W-1:0];

    // Clear the whole array on reset (reset wins over a same-edge write),
    // otherwise store data at the addressed location.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memWrite) begin
            mem[idx] <= data;
        end
    end

    // Combinational read; no write bypass, so a same-address write shows
    // up only after the capturing edge.
    assign out = memRead ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read values,
// a monitor samples out on each read strobe and compares.
module tb_data_memory;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memWrite = 1'b0;
    logic       memRead = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] data = '0;
    logic [7:0] out;

    typedef struct {
        logic [7:0] v;
        string      nm;
    } exp_t;

    exp_t   sb_q[$];
    event   smp;
    int     tests = 0;
    int     fails = 0;
    logic [7:0] ref_mem [256];

    data_memory dut (
        .clk      (clk),
        .memWrite (memWrite),
        .memRead  (memRead),
        .address  (address),
        .data     (data),
        .out      (out),
        .rst      (rst)
    );

    always #5 clk = ~clk;

    // Monitor: on each strobe let out settle, then pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(smp);
            #1;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: strobe with empty scoreboard, out=%02h", out);
            end else begin
                e = sb_q.pop_front();
                if (out !== e.v) begin
                    fails++;
                    $display("FAIL %s: out=%02h expected=%02h (addr=%0d rd=%0b)",
                             e.nm, out, e.v, address, memRead);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a read and queue what the model says it must return.
    task automatic rd(input logic [7:0] a, input logic r, input string nm);
        exp_t e;
        address = a;
        memRead = r;
        e.v  = r ? ref_mem[a] : 8'h00;
        e.nm = nm;
        sb_q.push_back(e);
        -> smp;
        #2;
    endtask

    // One clock edge with the given controls; model applies reset priority.
    task automatic cyc(input logic r, input logic we, input logic [7:0] a,
                       input logic [7:0] d);
        rst = r;
        memWrite = we;
        address = a;
        data = d;
        @(posedge clk);
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        end else if (we) begin
            ref_mem[a] = d;
        end
        #1;
        rst = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   wait_cnt;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;

        // 1. reset clear
        cyc(1'b1, 1'b0, 8'd0, 8'h00);
        rd(8'd19, 1'b1, "rst_a19");
        rd(8'd23, 1'b1, "rst_a23");
        rd(8'd255, 1'b1, "rst_a255");
        rd(8'd0, 1'b1, "rst_a0");
        rd(8'd19, 1'b0, "rst_rd0");

        // 2. write held two edges, then read
        memRead = 1'b0;
        cyc(1'b0, 1'b1, 8'd19, 8'h48);
        cyc(1'b0, 1'b1, 8'd19, 8'h48);
        rd(8'd19, 1'b1, "wr_a19");

        // 3. second location
        cyc(1'b0, 1'b1, 8'd23, 8'hAA);
        rd(8'd23, 1'b1, "wr_a23");
        rd(8'd19, 1'b1, "keep_a19");

        // 4. read gating within one cycle
        sync();
        rd(8'd23, 1'b0, "gate_off");
        rd(8'd23, 1'b1, "gate_on");

        // 5. reset priority over same-edge write
        cyc(1'b1, 1'b1, 8'd5, 8'h77);
        rd(8'd5, 1'b1, "rstpri_a5");
        rd(8'd19, 1'b1, "rstpri_a19");
        cyc(1'b0, 1'b1, 8'd5, 8'h77);
        rd(8'd5, 1'b1, "post_rst_a5");

        // 6. same-address write while reading, no bypass
        cyc(1'b0, 1'b1, 8'd23, 8'hAA);
        sync();
        memWrite = 1'b1;
        data = 8'h55;
        rd(8'd23, 1'b1, "raw_before");
        @(posedge clk);
        ref_mem[23] = 8'h55;
        #1;
        memWrite = 1'b0;
        rd(8'd23, 1'b1, "raw_after");

        // Random mix of writes, reads and occasional resets.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [7:0]  a;
            op = $urandom_range(0, 99);
            a  = (op % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            if (op < 3) begin
                cyc(1'b1, 1'($urandom), a, 8'($urandom));
            end else if (op < 50) begin
                cyc(1'b0, 1'b1, a, 8'($urandom));
            end else begin
                rd(a, ($urandom_range(0, 3) != 0), "rand_rd");
            end
        end

        // Drain with a bounded wait.
        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 100) begin
            #1;
            wait_cnt++;
        end
        #2;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable 256×8 data memory for the processor datapath; serves the MEM stage's loads and stores. Stores are synchronous, on the rising clock edge. Loads are combinational and gated by a read enable. A synchronous reset clears the entire array.

## Interface

Parameters:
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_WIDTH`, 8: address width in bits.
- `DEPTH`, 2**ADDR_WIDTH (256): number of words.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `memWrite`  input  1  write enable.
- `memRead`  input  1  read enable.
- `address`  input  ADDR_WIDTH  word address.
- `data`  input  DATA_WIDTH  write data.
- `out`  output  DATA_WIDTH  read data.

Port order is `clk, memWrite, memRead, address, data, out`, with `rst` appended last. Only the clock is required; the polarity and synchronicity of `rst` are fixed as stated above.

## Operation

- **Storage:** array `mem[0:DEPTH-1]` of DATA_WIDTH bits.
- **Reset:** on a rising edge with `rst`=1, every location is cleared to 0. Reset has priority over `memWrite`, and no write happens in that cycle.
- **Write:** on a rising edge with `rst`=0 and `memWrite`=1, `mem[address]` is loaded with `data`. All other locations are unchanged.
- **Read:** the read path is purely combinational.
  - `out` = `mem[address]` when `memRead`=1.
  - `out` = 0 when `memRead`=0.
- **Simultaneous read and write, same address:** before the edge `out` shows the old contents. After the edge `out` shows the newly written value; there is no bypass.
- **Addressing:** every address in 0..DEPTH-1 is valid, and there is no out-of-range case at the default width. If DEPTH < 2**ADDR_WIDTH, only the low log2(DEPTH) bits index the array, so addresses wrap.
- **X/undefined inputs:** there are no error flags, and no protection against X values.

## Timing

- **Write latency:** 1 edge. Data is visible on `out` combinationally immediately after the capturing edge, provided `memRead`=1.
- **Read latency:** 0 cycles. `out` follows changes on `address` and `memRead` within the same cycle.
- **Reset value of `out`:** 0. After reset every location holds 0, so `out` is 0 regardless of `memRead`.
- **Reset mid-operation:** a write asserted in the same cycle as `rst` is discarded. Writes resume on the first edge after `rst` deasserts.
- **`memWrite` held high across several edges:** rewrites the same location each edge, which is harmless.

## Structure

- Shared package `data_memory_pkg` holds the default constants:
  - `DM_DATA_WIDTH`=8
  - `DM_ADDR_WIDTH`=8
  - `DM_DEPTH`=256
- The module takes its parameter defaults from this package.
- Flat design; no sub-module is needed. The array, one clocked process (reset/write) and one combinational read assignment are sufficient.
- Keep the reset loop synthesizable: a for loop over DEPTH.

## Test plan

1. **Reset clear:** assert `rst` for 1 edge, then `memRead`=1 with `address`=19, 23 and 255 → `out`=0x00 for each.
2. **Write/read:** `address`=19, `data`=0x48, `memWrite`=1 for 2 edges, then `memWrite`=0, `memRead`=1 → `out`=0x48.
3. **Second location:**
   - Write 0xAA to address 23 → read 23 gives 0xAA.
   - Read 19 → still 0x48.
4. **Read gating:** `memRead`=0 with `address`=23 → `out`=0x00. Raising `memRead` → 0xAA in the same cycle, with no clock edge.
5. **Reset priority:**
   - `rst`=1 and `memWrite`=1, `address`=5, `data`=0x77 on the same edge → read 5 gives 0x00, read 19 gives 0x00.
   - Next edge with `rst`=0 writing 0x77 → read 5 gives 0x77.
6. **Same-address write while reading:** `memRead`=1, `address`=23 holds 0xAA, write 0x55.
   - `out`=0xAA before the edge.
   - `out`=0x55 after the edge.
